// File: rtl/rotor_step_engine.sv
// Cascaded odometer-style rotor bank: loads positions or steps them forward/backward
// with carry/borrow ripple, one step per clock while running.
module rotor_step_engine #(
  parameter int NUM_ROTORS = 3,
  parameter int POS_W      = 5,
  parameter int MODULUS    = 26,
  parameter int CNT_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_load,
  input  logic                        cmd_dir,
  input  logic [CNT_W-1:0]            cmd_count,
  input  logic [NUM_ROTORS*POS_W-1:0] pos_in,
  input  logic                        abort,
  output logic [NUM_ROTORS*POS_W-1:0] pos_out,
  output logic                        busy,
  output logic                        done,
  output logic                        wrap,
  output logic                        load_err
);

  localparam int PW = NUM_ROTORS * POS_W;
  localparam logic [POS_W-1:0] MAX_POS = POS_W'(MODULUS - 1);
  localparam logic [POS_W:0]   MOD_EXT = (POS_W + 1)'(MODULUS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic              dir;
  logic              accept;
  logic [PW-1:0]     stepped;
  logic              carry;
  logic [PW-1:0]     loaded;
  logic              bad_load;

  assign accept = cmd_valid && cmd_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_load || (cmd_count == '0)) begin
            state_next = DONE;
          end else begin
            state_next = RUN;
          end
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (abort || (cnt == CNT_W'(1))) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State decode outputs
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    cmd_ready = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    done      = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

  // One step of the whole bank; carry doubles as borrow and ends as the top-rotor wrap
  always_comb begin
    stepped = pos_out;
    carry   = 1'b1;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      if (carry) begin
        if (!dir) begin
          if (pos_out[i*POS_W +: POS_W] == MAX_POS) begin
            stepped[i*POS_W +: POS_W] = '0;
            carry = 1'b1;
          end else begin
            stepped[i*POS_W +: POS_W] = pos_out[i*POS_W +: POS_W] + POS_W'(1);
            carry = 1'b0;
          end
        end else begin
          if (pos_out[i*POS_W +: POS_W] == '0) begin
            stepped[i*POS_W +: POS_W] = MAX_POS;
            carry = 1'b1;
          end else begin
            stepped[i*POS_W +: POS_W] = pos_out[i*POS_W +: POS_W] - POS_W'(1);
            carry = 1'b0;
          end
        end
      end else begin
        stepped[i*POS_W +: POS_W] = pos_out[i*POS_W +: POS_W];
      end
    end
  end

  // Range-check load values; out-of-range rotors are forced to zero
  always_comb begin
    loaded   = '0;
    bad_load = 1'b0;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      if ({1'b0, pos_in[i*POS_W +: POS_W]} >= MOD_EXT) begin
        loaded[i*POS_W +: POS_W] = '0;
        bad_load = 1'b1;
      end else begin
        loaded[i*POS_W +: POS_W] = pos_in[i*POS_W +: POS_W];
      end
    end
  end

  // Positions, step counter, latched direction and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_out  <= '0;
      cnt      <= '0;
      dir      <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (cmd_load) begin
              pos_out  <= loaded;
              load_err <= load_err | bad_load;
              cnt      <= '0;
            end else begin
              cnt <= cmd_count;
              dir <= cmd_dir;
            end
          end
        end
        RUN: begin
          if (abort) begin
            cnt <= '0;
          end else begin
            pos_out <= stepped;
            wrap    <= carry;
            cnt     <= cnt - CNT_W'(1);
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotor_step_engine.sv
// Scoreboard bench for rotor_step_engine: expected positions are queued at command
// issue and compared whenever done pulses; scenario tasks check timing and flags.
module tb_rotor_step_engine;

  localparam int NR  = 3;
  localparam int PSW = 5;
  localparam int MOD = 26;
  localparam int CW  = 8;
  localparam int W   = NR * PSW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_load = 1'b0;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_count = '0;
  logic [W-1:0]  pos_in = '0;
  logic          abort = 1'b0;
  logic [W-1:0]  pos_out;
  logic          busy;
  logic          done;
  logic          wrap;
  logic          load_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int wrap_cnt = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] sb_exp;
  logic [W-1:0] model_pos = '0;

  always #5 clk = ~clk;

  rotor_step_engine #(
    .NUM_ROTORS(NR),
    .POS_W(PSW),
    .MODULUS(MOD),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_load(cmd_load),
    .cmd_dir(cmd_dir),
    .cmd_count(cmd_count),
    .pos_in(pos_in),
    .abort(abort),
    .pos_out(pos_out),
    .busy(busy),
    .done(done),
    .wrap(wrap),
    .load_err(load_err)
  );

  function automatic logic [W-1:0] pack3(input int r2, input int r1, input int r0);
    return {PSW'(r2), PSW'(r1), PSW'(r0)};
  endfunction

  // Treat the bank as one base-MOD number and add/subtract the step count
  function automatic logic [W-1:0] model_step(input logic [W-1:0] p, input bit d, input int n);
    int v;
    int tot;
    logic [W-1:0] r;
    v = 0;
    tot = 1;
    for (int i = NR - 1; i >= 0; i--) begin
      v = v * MOD + int'(p[i*PSW +: PSW]);
      tot = tot * MOD;
    end
    if (d) v = ((v - (n % tot)) + tot) % tot;
    else   v = (v + n) % tot;
    r = '0;
    for (int i = 0; i < NR; i++) begin
      r[i*PSW +: PSW] = PSW'(v % MOD);
      v = v / MOD;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] sanitize(input logic [W-1:0] p);
    logic [W-1:0] r;
    r = p;
    for (int i = 0; i < NR; i++) begin
      if (int'(p[i*PSW +: PSW]) >= MOD) r[i*PSW +: PSW] = '0;
    end
    return r;
  endfunction

  // Scoreboard: every done pulse retires the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (wrap) wrap_cnt++;
      if (done) begin
        done_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_done: unexpected done, pos_out=%h, no command pending", pos_out);
        end else begin
          sb_exp = sb.pop_front();
          if (pos_out !== sb_exp) begin
            errors++;
            $display("FAIL sb_pos: pos_out=%h expected=%h", pos_out, sb_exp);
          end
        end
      end
    end
  end

  task automatic clr_counts();
    done_cnt = 0;
    busy_cnt = 0;
    wrap_cnt = 0;
  endtask

  task automatic send(input bit ld, input bit d, input int count, input logic [W-1:0] pin,
                      input int nsteps);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_dir   = d;
    cmd_count = CW'(count);
    pos_in    = pin;
    if (ld) model_pos = sanitize(pin);
    else    model_pos = model_step(model_pos, d, nsteps);
    sb.push_back(model_pos);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: cmd_ready=%b after %0d cycles, expected 1", cmd_ready, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pos_out !== '0 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: pos=%h busy=%b done=%b wrap=%b err=%b expected all 0",
               pos_out, busy, done, wrap, load_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: cmd_ready=%b expected 1", cmd_ready);
    end
  endtask

  task automatic test_fwd_carry();
    send(1'b1, 1'b0, 0, pack3(0, 0, 24), 0);
    wait_idle(10);
    clr_counts();
    send(1'b0, 1'b0, 3, '0, 3);
    wait_idle(20);
    checks++;
    if (pos_out !== pack3(0, 1, 1)) begin
      errors++;
      $display("FAIL fwd_carry_pos: pos_out=%h expected=%h", pos_out, pack3(0, 1, 1));
    end
    checks++;
    if (busy_cnt != 3 || done_cnt != 1 || wrap_cnt != 0) begin
      errors++;
      $display("FAIL fwd_carry_timing: busy=%0d done=%0d wrap=%0d expected 3/1/0",
               busy_cnt, done_cnt, wrap_cnt);
    end
  endtask

  task automatic test_rev_wrap();
    send(1'b1, 1'b0, 0, pack3(0, 0, 0), 0);
    wait_idle(10);
    clr_counts();
    send(1'b0, 1'b1, 1, '0, 1);
    wait_idle(10);
    checks++;
    if (pos_out !== pack3(25, 25, 25) || wrap_cnt != 1 || done_cnt != 1 || busy_cnt != 1) begin
      errors++;
      $display("FAIL rev_wrap: pos=%h wrap=%0d done=%0d busy=%0d expected %h/1/1/1",
               pos_out, wrap_cnt, done_cnt, busy_cnt, pack3(25, 25, 25));
    end
  endtask

  task automatic test_fwd_wrap();
    send(1'b1, 1'b0, 0, pack3(25, 25, 25), 0);
    wait_idle(10);
    clr_counts();
    send(1'b0, 1'b0, 1, '0, 1);
    wait_idle(10);
    checks++;
    if (pos_out !== pack3(0, 0, 0) || wrap_cnt != 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL fwd_wrap: pos=%h wrap=%0d done=%0d expected 0/1/1", pos_out, wrap_cnt, done_cnt);
    end
  endtask

  task automatic test_load_err();
    send(1'b1, 1'b0, 0, pack3(3, 7, 30), 0);
    wait_idle(10);
    checks++;
    if (pos_out !== pack3(3, 7, 0) || load_err !== 1'b1) begin
      errors++;
      $display("FAIL load_range: pos=%h err=%b expected %h/1", pos_out, load_err, pack3(3, 7, 0));
    end
    send(1'b0, 1'b0, 2, '0, 2);
    wait_idle(10);
    checks++;
    if (pos_out !== pack3(3, 7, 2) || load_err !== 1'b1) begin
      errors++;
      $display("FAIL load_err_sticky: pos=%h err=%b expected %h/1", pos_out, load_err, pack3(3, 7, 2));
    end
  endtask

  task automatic test_abort();
    send(1'b1, 1'b0, 0, pack3(0, 0, 0), 0);
    wait_idle(10);
    clr_counts();
    send(1'b0, 1'b0, 10, '0, 4);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b0 || pos_out !== pack3(0, 0, 4)) begin
      errors++;
      $display("FAIL abort_done: done=%b ready=%b pos=%h expected 1/0/%h",
               done, cmd_ready, pos_out, pack3(0, 0, 4));
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || busy_cnt != 5 || done_cnt != 1) begin
      errors++;
      $display("FAIL abort_ready: ready=%b done=%b busy=%0d dones=%0d expected 1/0/5/1",
               cmd_ready, done, busy_cnt, done_cnt);
    end
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || pos_out !== pack3(0, 0, 4) || done_cnt != 1) begin
      errors++;
      $display("FAIL abort_idle: ready=%b pos=%h dones=%0d expected 1/%h/1",
               cmd_ready, pos_out, done_cnt, pack3(0, 0, 4));
    end
  endtask

  task automatic test_ignore_busy();
    clr_counts();
    send(1'b0, 1'b0, 3, '0, 3);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_load  = 1'b1;
    pos_in    = pack3(9, 9, 9);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_ready: ready=%b busy=%b expected 0/1", cmd_ready, busy);
    end
    cmd_valid = 1'b0;
    wait_idle(10);
    checks++;
    if (pos_out !== pack3(0, 0, 7) || done_cnt != 1) begin
      errors++;
      $display("FAIL busy_ignore: pos=%h dones=%0d expected %h/1", pos_out, done_cnt, pack3(0, 0, 7));
    end
  endtask

  task automatic test_reset_mid_run();
    send(1'b0, 1'b0, 10, '0, 10);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (pos_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_run: pos=%h busy=%b done=%b expected 0/0/0", pos_out, busy, done);
    end
    sb.delete();
    model_pos = '0;
    clr_counts();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 0 || load_err !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_no_done: dones=%0d err=%b ready=%b expected 0/0/1", done_cnt, load_err, cmd_ready);
    end
    send(1'b0, 1'b0, 0, '0, 0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || pos_out !== '0) begin
      errors++;
      $display("FAIL zero_count: done=%b pos=%h expected 1/0", done, pos_out);
    end
    wait_idle(10);
    checks++;
    if (busy_cnt != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL zero_count_timing: busy=%0d dones=%0d expected 0/1", busy_cnt, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    bit d;
    send(1'b1, 1'b0, 0, pack3(12, 0, 20), 0);
    wait_idle(10);
    for (int k = 0; k < 8; k++) begin
      d   = 1'($urandom_range(0, 1));
      cnt = int'($urandom_range(0, 60));
      send(1'b0, d, cnt, '0, cnt);
      wait_idle(80);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_carry();
    test_rev_wrap();
    test_fwd_wrap();
    test_load_err();
    test_abort();
    test_ignore_busy();
    test_reset_mid_run();
    test_back_to_back();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
